// File: rtl/spi_pkg.sv
// Shared SPI definitions for the spi_slave codebase slice.
// Contents: mode constants (mode 0 only), synchronizer depth, minimum
// sysclk/sck ratio and the slave FSM state type.
package spi_pkg;

    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

    localparam int SPI_SYNC_STAGES     = 2;
    localparam int SPI_MIN_CLOCK_RATIO = 8;

    typedef enum logic {
        SPI_IDLE   = 1'b0,
        SPI_ACTIVE = 1'b1
    } spi_state_t;

endpackage

// File: rtl/spi_sync_2ff.sv
// Single-bit synchronizer for an asynchronous input into the sysclk domain.
// Ports:
//   sysclk    in   system clock
//   sysreset  in   asynchronous active-high reset
//   d         in   asynchronous input
//   q         out  synchronized output
// Parameter RESET_VAL is the value every stage takes during reset, so the
// output looks like the pin's idle level straight out of reset.
module spi_sync_2ff
    import spi_pkg::*;
#(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic sysclk,
    input  logic sysreset,
    input  logic d,
    output logic q
);

    logic [SPI_SYNC_STAGES-1:0] sr;

    always_ff @(posedge sysclk or posedge sysreset) begin
        if (sysreset) begin
            sr <= {SPI_SYNC_STAGES{RESET_VAL}};
        end else begin
            sr <= {sr[SPI_SYNC_STAGES-2:0], d};
        end
    end

    assign q = sr[SPI_SYNC_STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// SPI slave, mode 0 (CPOL=0, CPHA=0), MSB first, WIDTH-bit words.
// SPI pins are asynchronous; they are synchronized and edge-detected in the
// sysclk domain (edge-to-action latency 3 sysclk, sck <= sysclk/8).
//
// Optional build macro SPI_SLAVE_SCK_FILTER_EN: synchronized sck must hold a
// value for 2 consecutive samples before the edge is accepted (latency 4,
// sck <= sysclk/10). Undefined: no filter.
//
// Ports:
//   sysclk, sysreset      clock, async active-high reset
//   tx_data, tx_load      next word for the master / one-cycle write strobe
//   tx_full               holding register occupied
//   rx_data, rx_ready     last received word / sticky completion flag
//   rx_ack                one-cycle strobe clearing rx_ready, overrun, frame_err
//   overrun, frame_err    sticky error flags
//   busy                  frame active
//   spi_cs, spi_sck, spi_mo   async SPI inputs (cs active low)
//   spi_mi, spi_mi_en     slave data out and its tri-state enable
//
// state      | meaning
// -----------+---------------------------------------------------------
// SPI_IDLE   | cs high (or not yet re-armed after reset); sck ignored
// SPI_ACTIVE | frame in progress; shift on sck, words complete per WIDTH
module spi_slave
    import spi_pkg::*;
#(
    parameter int             WIDTH   = 8,
    parameter int             MSB     = WIDTH - 1,
    parameter logic [MSB:0]   TX_FILL = '0
) (
    input  logic         sysclk,
    input  logic         sysreset,
    input  logic [MSB:0] tx_data,
    input  logic         tx_load,
    output logic         tx_full,
    output logic [MSB:0] rx_data,
    output logic         rx_ready,
    input  logic         rx_ack,
    output logic         overrun,
    output logic         frame_err,
    output logic         busy,
    input  logic         spi_cs,
    input  logic         spi_sck,
    input  logic         spi_mo,
    output logic         spi_mi,
    output logic         spi_mi_en
);

    localparam int           CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic cs_s, sck_s, mo_s;
    logic cs_d, sck_d;
    logic [1:0] warm;
    logic armed;

    spi_sync_2ff #(.RESET_VAL(1'b1)) u_sync_cs (
        .sysclk(sysclk), .sysreset(sysreset), .d(spi_cs), .q(cs_s)
    );
    spi_sync_2ff #(.RESET_VAL(1'b0)) u_sync_sck (
        .sysclk(sysclk), .sysreset(sysreset), .d(spi_sck), .q(sck_s)
    );
    spi_sync_2ff #(.RESET_VAL(1'b0)) u_sync_mo (
        .sysclk(sysclk), .sysreset(sysreset), .d(spi_mo), .q(mo_s)
    );

    // After reset the synchronizer holds its reset value for two cycles. A
    // frame is only honored once a genuine cs-high sample has been seen, so a
    // cs held low across reset cannot fake a falling edge.
    always_ff @(posedge sysclk or posedge sysreset) begin
        if (sysreset) begin
            cs_d  <= 1'b1;
            sck_d <= 1'b0;
            warm  <= 2'b00;
            armed <= 1'b0;
        end else begin
            cs_d  <= cs_s;
            sck_d <= sck_s;
            warm  <= {warm[0], 1'b1};
            armed <= armed | (warm[1] & cs_s);
        end
    end

    logic cs_fall, cs_rise, sck_rise, sck_fall;

    assign cs_fall = armed & cs_d & ~cs_s;
    assign cs_rise = ~cs_d & cs_s;

`ifdef SPI_SLAVE_SCK_FILTER_EN
    logic sck_f;

    // sck_f is the accepted sck level; it only follows two equal samples.
    always_ff @(posedge sysclk or posedge sysreset) begin
        if (sysreset) begin
            sck_f <= 1'b0;
        end else if (sck_s == sck_d) begin
            sck_f <= sck_d;
        end
    end

    assign sck_rise = (sck_s == sck_d) &  sck_d & ~sck_f;
    assign sck_fall = (sck_s == sck_d) & ~sck_d &  sck_f;
`else
    assign sck_rise =  sck_s & ~sck_d;
    assign sck_fall = ~sck_s &  sck_d;
`endif

    spi_state_t state, state_nxt;

    logic [MSB:0]  r;
    logic [MSB:0]  tx_hold;
    logic [CW-1:0] cnt;
    logic          b;

    logic start_word, capture, shift_bit, word_done, leave, abort_word;

    always_ff @(posedge sysclk or posedge sysreset) begin
        if (sysreset) begin
            state <= SPI_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        start_word = 1'b0;
        capture    = 1'b0;
        shift_bit  = 1'b0;
        word_done  = 1'b0;
        leave      = 1'b0;
        abort_word = 1'b0;
        case (state)
            SPI_IDLE: begin
                if (cs_fall) begin
                    state_nxt  = SPI_ACTIVE;
                    start_word = 1'b1;
                end
            end
            SPI_ACTIVE: begin
                capture   = sck_rise;
                shift_bit = sck_fall;
                word_done = sck_fall && (cnt == CNT_ONE);
                if (cs_rise) begin
                    state_nxt = SPI_IDLE;
                    leave     = 1'b1;
                    // A word finishing on the same cycle as cs rising is good.
                    abort_word = (cnt != CNT_FULL) && !word_done;
                end
            end
            default: state_nxt = SPI_IDLE;
        endcase
    end

    // A word ending as cs rises does not reload, so a pending tx word stays
    // queued for the next frame instead of being shifted into nothing.
    logic         reload;
    logic [MSB:0] tx_word;

    assign reload  = start_word | (word_done & ~leave);
    assign tx_word = tx_load ? tx_data : (tx_full ? tx_hold : TX_FILL);

    always_ff @(posedge sysclk or posedge sysreset) begin
        if (sysreset) begin
            r         <= '0;
            tx_hold   <= '0;
            tx_full   <= 1'b0;
            cnt       <= '0;
            b         <= 1'b0;
            rx_data   <= '0;
            rx_ready  <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (capture) begin
                b <= mo_s;
            end

            if (reload) begin
                r       <= tx_word;
                cnt     <= CNT_FULL;
                tx_full <= 1'b0;
            end else begin
                if (shift_bit) begin
                    r   <= {r[MSB-1:0], b};
                    cnt <= cnt - CNT_ONE;
                end
                if (tx_load) begin
                    tx_hold <= tx_data;
                    tx_full <= 1'b1;
                end
            end

            if (leave) begin
                cnt <= '0;
            end

            if (word_done) begin
                rx_data <= {r[MSB-1:0], b};
            end

            if (word_done) begin
                rx_ready <= 1'b1;
            end else if (rx_ack) begin
                rx_ready <= 1'b0;
            end

            if (word_done && rx_ready && !rx_ack) begin
                overrun <= 1'b1;
            end else if (rx_ack) begin
                overrun <= 1'b0;
            end

            if (abort_word) begin
                frame_err <= 1'b1;
            end else if (rx_ack) begin
                frame_err <= 1'b0;
            end
        end
    end

    assign busy      = (state == SPI_ACTIVE);
    assign spi_mi_en = busy;
    assign spi_mi    = busy & r[MSB];

endmodule

// File: tb/tb_spi_slave.sv
// Testbench for spi_slave (WIDTH=8). The bench plays the SPI master at
// sck = sysclk/16. Expected received words are queued when a word is sent
// and checked by a monitor whenever the DUT presents a completed word.
module tb_spi_slave;

    localparam int HALF = 8;
`ifdef SPI_SLAVE_SCK_FILTER_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic       sysclk = 1'b0;
    logic       sysreset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_load = 1'b0;
    logic       tx_full;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rx_ack = 1'b0;
    logic       overrun;
    logic       frame_err;
    logic       busy;
    logic       spi_cs = 1'b1;
    logic       spi_sck = 1'b0;
    logic       spi_mo = 1'b0;
    logic       spi_mi;
    logic       spi_mi_en;

    always #5 sysclk = ~sysclk;

    spi_slave #(.WIDTH(8)) dut (
        .sysclk(sysclk), .sysreset(sysreset),
        .tx_data(tx_data), .tx_load(tx_load), .tx_full(tx_full),
        .rx_data(rx_data), .rx_ready(rx_ready), .rx_ack(rx_ack),
        .overrun(overrun), .frame_err(frame_err), .busy(busy),
        .spi_cs(spi_cs), .spi_sck(spi_sck), .spi_mo(spi_mo),
        .spi_mi(spi_mi), .spi_mi_en(spi_mi_en)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       ovr;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] mi_q[$];
    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic load_tx(input logic [7:0] v);
        tx_data = v;
        tx_load = 1'b1;
        cyc(1);
        tx_load = 1'b0;
        cyc(1);
    endtask

    task automatic ack();
        rx_ack = 1'b1;
        cyc(1);
        rx_ack = 1'b0;
        cyc(1);
    endtask

    task automatic cs_low();
        spi_cs = 1'b0;
        cyc(HALF);
    endtask

    task automatic cs_high();
        spi_cs = 1'b1;
        cyc(HALF);
    endtask

    // Shifts the top nbits of w, MSB first. The low phase before the bit
    // after 4 falls can carry a tx_load or an sck glitch; the low phase after
    // the last fall can carry an rx_ack aligned with the completion cycle.
    task automatic xfer(input logic [7:0] w, input int nbits, input bit ack_last,
                        input bit load_mid, input logic [7:0] load_val, input bit glitch);
        logic [7:0] got;
        got = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            spi_mo = w[i];
            if (load_mid && i == 3) begin
                tx_data = load_val;
                tx_load = 1'b1;
                cyc(1);
                tx_load = 1'b0;
                cyc(HALF - 1);
            end else if (glitch && i == 3) begin
                cyc(3);
                spi_sck = 1'b1;
                cyc(1);
                spi_sck = 1'b0;
                cyc(HALF - 4);
            end else begin
                cyc(HALF);
            end
            spi_sck = 1'b1;
            got[i] = spi_mi;
            cyc(HALF);
            spi_sck = 1'b0;
        end
        if (ack_last) begin
            cyc(LAT - 1);
            rx_ack = 1'b1;
            cyc(1);
            rx_ack = 1'b0;
            cyc(HALF - LAT);
        end else begin
            cyc(HALF);
        end
        if (nbits == 8) begin
            if (mi_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL mi_word: got %0h with no expected word queued", got);
            end else begin
                chk("mi_word", got, mi_q.pop_front());
            end
        end
    endtask

    task automatic send(input logic [7:0] w, input logic [7:0] mi_exp, input bit ovr_exp);
        exp_q.push_back('{data: w, ovr: ovr_exp});
        mi_q.push_back(mi_exp);
    endtask

    // Monitor: a completed word shows as rx_ready rising or rx_data changing.
    logic       prev_rdy = 1'b0;
    logic [7:0] prev_data = 8'h00;
    initial begin
        forever begin
            @(negedge sysclk);
            if (!sysreset && ((rx_ready && !prev_rdy) || (rx_data != prev_data))) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL rx_word: unexpected word %0h", rx_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rx_data", rx_data, e.data);
                    chk("overrun_at_done", overrun, e.ovr);
                end
            end
            prev_rdy  = rx_ready;
            prev_data = rx_data;
        end
    end

    initial begin
        int budget;
        cyc(3);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_rx_ready", rx_ready, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_tx_full", tx_full, 0);
        chk("rst_busy", busy, 0);
        chk("rst_spi_mi_en", spi_mi_en, 0);
        sysreset = 1'b0;
        cyc(4);

        // Basic exchange: slave preloaded 0x3C, master sends 0xA5.
        load_tx(8'h3C);
        chk("tx_full_loaded", tx_full, 1);
        send(8'hA5, 8'h3C, 1'b0);
        cs_low();
        chk("busy_active", busy, 1);
        chk("mi_en_active", spi_mi_en, 1);
        xfer(8'hA5, 8, 0, 0, 8'h00, 0);
        cs_high();
        chk("rx_ready_set", rx_ready, 1);
        chk("tx_full_consumed", tx_full, 0);
        chk("busy_idle", busy, 0);
        ack();
        chk("rx_ready_acked", rx_ready, 0);

        // No tx word pending: TX_FILL goes out.
        send(8'h5A, 8'h00, 1'b0);
        cs_low();
        xfer(8'h5A, 8, 0, 0, 8'h00, 0);
        cs_high();
        ack();

        // Two words under one cs, reload of 0x42 mid-word, overrun on second.
        load_tx(8'h81);
        send(8'h11, 8'h81, 1'b0);
        send(8'h22, 8'h42, 1'b1);
        cs_low();
        xfer(8'h11, 8, 0, 1, 8'h42, 0);
        xfer(8'h22, 8, 0, 0, 8'h00, 0);
        cs_high();
        chk("overrun_set", overrun, 1);
        chk("rx_data_second", rx_data, 8'h22);
        chk("tx_full_after_reload", tx_full, 0);
        ack();
        chk("overrun_acked", overrun, 0);

        // Partial word: cs raised after 4 falls.
        cs_low();
        xfer(8'hF0, 4, 0, 0, 8'h00, 0);
        cs_high();
        chk("frame_err_set", frame_err, 1);
        chk("partial_rx_ready", rx_ready, 0);
        chk("partial_rx_data", rx_data, 8'h22);
        ack();
        chk("frame_err_acked", frame_err, 0);

        // rx_ack on the exact completion cycle.
        send(8'h33, 8'h00, 1'b0);
        cs_low();
        xfer(8'h33, 8, 0, 0, 8'h00, 0);
        cs_high();
        send(8'h44, 8'h00, 1'b0);
        cs_low();
        xfer(8'h44, 8, 1, 0, 8'h00, 0);
        cs_high();
        chk("ack_collide_rx_ready", rx_ready, 1);
        chk("ack_collide_overrun", overrun, 0);

        // Reset mid-word with a tx word pending and rx_ready set.
        cs_low();
        load_tx(8'h55);
        xfer(8'h0F, 4, 0, 0, 8'h00, 0);
        sysreset = 1'b1;
        cyc(2);
        chk("mid_rst_rx_data", rx_data, 8'h00);
        chk("mid_rst_rx_ready", rx_ready, 0);
        chk("mid_rst_tx_full", tx_full, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_spi_mi", spi_mi, 0);
        chk("mid_rst_spi_mi_en", spi_mi_en, 0);
        sysreset = 1'b0;
        cyc(8);
        chk("no_frame_after_rst", busy, 0);
        cs_high();
        load_tx(8'h00);
        chk("tx_full_after_rst", tx_full, 1);
        send(8'hFF, 8'h00, 1'b0);
        cs_low();
        xfer(8'hFF, 8, 0, 0, 8'h00, 0);
        cs_high();
        chk("rx_ready_after_rst_frame", rx_ready, 1);
        ack();

`ifdef SPI_SLAVE_SCK_FILTER_EN
        // One-cycle sck glitch mid-word must be rejected.
        load_tx(8'h96);
        send(8'hC3, 8'h96, 1'b0);
        cs_low();
        xfer(8'hC3, 8, 0, 0, 8'h00, 1);
        cs_high();
        chk("glitch_frame_err", frame_err, 0);
        ack();
`endif

        budget = 200;
        while (exp_q.size() != 0 && budget > 0) begin
            cyc(1);
            budget--;
        end
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL rx_pending: got %0d words still expected, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
